ram_access_arbiter: RTL and testbench

Two-requester arbiter that shares the solver's dual-read/single-write state RAM between requester A (interface loader) and requester B (solver core). Round-robin ownership with a bounded burst length. The owner drives both RAM read addresses and the write port. RAM read data is registered and returned with a per-requester valid pulse.

---
 rtl/ram_access_arbiter_if.sv | 57 +++++
 rtl/ram_access_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_access_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_arbiter_if.sv
// ram_access_arbiter_if
// Bundles every non-clock/reset signal of the RAM access arbiter: the two
// requester ports (A = interface loader, B = solver core), the shared
// registered read data, and the state-RAM port.
//   slave  : arbiter side (takes requests and RAM read data, drives grants,
//            read data and RAM controls)
//   master : environment side (requesters and RAM)
interface ram_access_arbiter_if #(
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned DATA_WIDTH    = 64
);
    // Requester A
    logic                     req_a;
    logic                     we_a;
    logic [ADDRESS_WIDTH-1:0] addr_rd1_a;
    logic [ADDRESS_WIDTH-1:0] addr_rd2_a;
    logic [ADDRESS_WIDTH-1:0] addr_wr_a;
    logic [DATA_WIDTH-1:0]    wdata_a;
    logic                     gnt_a;
    logic                     rvalid_a;
    // Requester B
    logic                     req_b;
    logic                     we_b;
    logic [ADDRESS_WIDTH-1:0] addr_rd1_b;
    logic [ADDRESS_WIDTH-1:0] addr_rd2_b;
    logic [ADDRESS_WIDTH-1:0] addr_wr_b;
    logic [DATA_WIDTH-1:0]    wdata_b;
    logic                     gnt_b;
    logic                     rvalid_b;
    // Shared registered read data
    logic [DATA_WIDTH-1:0]    rdata1;
    logic [DATA_WIDTH-1:0]    rdata2;
    // State RAM port
    logic                     ram_wr_enable;
    logic [ADDRESS_WIDTH-1:0] ram_address_rd1;
    logic [ADDRESS_WIDTH-1:0] ram_address_rd2;
    logic [ADDRESS_WIDTH-1:0] ram_address_wr;
    logic [DATA_WIDTH-1:0]    ram_data_in;
    logic [DATA_WIDTH-1:0]    ram_data_out1;
    logic [DATA_WIDTH-1:0]    ram_data_out2;

    modport slave (
        input  req_a, we_a, addr_rd1_a, addr_rd2_a, addr_wr_a, wdata_a,
        input  req_b, we_b, addr_rd1_b, addr_rd2_b, addr_wr_b, wdata_b,
        input  ram_data_out1, ram_data_out2,
        output gnt_a, rvalid_a, gnt_b, rvalid_b, rdata1, rdata2,
        output ram_wr_enable, ram_address_rd1, ram_address_rd2, ram_address_wr, ram_data_in
    );

    modport master (
        output req_a, we_a, addr_rd1_a, addr_rd2_a, addr_wr_a, wdata_a,
        output req_b, we_b, addr_rd1_b, addr_rd2_b, addr_wr_b, wdata_b,
        output ram_data_out1, ram_data_out2,
        input  gnt_a, rvalid_a, gnt_b, rvalid_b, rdata1, rdata2,
        input  ram_wr_enable, ram_address_rd1, ram_address_rd2, ram_address_wr, ram_data_in
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares a dual-read/single-write state RAM between requester A and
// requester B. Round-robin ownership with bursts capped at MAX_BURST beats
// while the other side waits. The owner steers both read addresses and the
// write port; read data is registered and returned with a per-requester
// one-cycle valid.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : ram_access_arbiter_if.slave (requests, grants, read data, RAM port)
module ram_access_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned MAX_BURST     = 8
) (
    input logic                CLK,
    input logic                RST,
    ram_access_arbiter_if.slave bus
);
    localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST - 1);

    typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;
    typedef enum logic {SideA, SideB} side_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    side_e                 last_q, last_d;
    logic                  gnt_a_q, gnt_b_q;
    logic                  rvalid_a_q, rvalid_b_q;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;
    logic                  beat_a, beat_b;
    logic [CntW-1:0]       cnt_sat;

    // Grants mirror the state register, so beats are qualified by them.
    assign beat_a  = gnt_a_q & bus.req_a;
    assign beat_b  = gnt_b_q & bus.req_b;
    assign cnt_sat = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.req_a && bus.req_b) begin
                    state_d = (last_q == SideB) ? StOwnA : StOwnB;
                end else if (bus.req_a) begin
                    state_d = StOwnA;
                end else if (bus.req_b) begin
                    state_d = StOwnB;
                end
            end
            StOwnA: begin
                if (!bus.req_a) begin
                    state_d = bus.req_b ? StOwnB : StIdle;
                    cnt_d   = '0;
                    last_d  = SideA;
                end else if (bus.req_b && cnt_q == CntMax) begin
                    // Burst exhausted: hand over directly, no idle cycle.
                    state_d = StOwnB;
                    cnt_d   = '0;
                    last_d  = SideA;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            StOwnB: begin
                if (!bus.req_b) begin
                    state_d = bus.req_a ? StOwnA : StIdle;
                    cnt_d   = '0;
                    last_d  = SideB;
                end else if (bus.req_a && cnt_q == CntMax) begin
                    state_d = StOwnA;
                    cnt_d   = '0;
                    last_d  = SideB;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Read data is captured from the RAM's combinational outputs at the beat
    // edge, i.e. before that same edge's write lands (old value on collision).
    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (beat_a || beat_b) begin
            rdata1_d = bus.ram_data_out1;
            rdata2_d = bus.ram_data_out2;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_q     <= SideB;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_a_q    <= (state_d == StOwnA);
            gnt_b_q    <= (state_d == StOwnB);
            rvalid_a_q <= beat_a;
            rvalid_b_q <= beat_b;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
        end
    end

    // RAM mux; driven from registered grants so reset clears it at once.
    always_comb begin
        bus.ram_wr_enable   = 1'b0;
        bus.ram_address_rd1 = '0;
        bus.ram_address_rd2 = '0;
        bus.ram_address_wr  = '0;
        bus.ram_data_in     = '0;
        if (gnt_a_q) begin
            bus.ram_wr_enable   = beat_a & bus.we_a;
            bus.ram_address_rd1 = bus.addr_rd1_a;
            bus.ram_address_rd2 = bus.addr_rd2_a;
            bus.ram_address_wr  = bus.addr_wr_a;
            bus.ram_data_in     = bus.wdata_a;
        end else if (gnt_b_q) begin
            bus.ram_wr_enable   = beat_b & bus.we_b;
            bus.ram_address_rd1 = bus.addr_rd1_b;
            bus.ram_address_rd2 = bus.addr_rd2_b;
            bus.ram_address_wr  = bus.addr_wr_b;
            bus.ram_data_in     = bus.wdata_b;
        end
    end

    assign bus.gnt_a    = gnt_a_q;
    assign bus.gnt_b    = gnt_b_q;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rvalid_b = rvalid_b_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.rdata2   = rdata2_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
// Drives both requesters against a RAM model, compares RAM-port steering and
// grants every cycle against a reference arbiter, and checks returned read
// data through a scoreboard drained by an independent monitor.
module tb_ram_access_arbiter;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 64;
    localparam int unsigned MB = 8;
    localparam int unsigned MemDepth = 8192;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_access_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_access_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MB)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // Environment RAM: combinational read, write at the rising edge.
    logic [DW-1:0] env_mem [0:MemDepth-1];
    assign bus.ram_data_out1 = env_mem[bus.ram_address_rd1];
    assign bus.ram_data_out2 = env_mem[bus.ram_address_rd2];
    always @(posedge clk) begin
        if (bus.ram_wr_enable) env_mem[bus.ram_address_wr] <= bus.ram_data_in;
    end

    // Reference model: owner 0 = nobody, 1 = A, 2 = B.
    int            m_owner;
    int            m_tenure;
    int            m_last;
    logic [DW-1:0] m_mem [0:MemDepth-1];

    typedef struct {
        int            due;
        logic [1:0]    who;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [103:0] ram_vec();
        return {bus.ram_wr_enable, bus.ram_address_rd1, bus.ram_address_rd2,
                bus.ram_address_wr, bus.ram_data_in};
    endfunction

    task automatic model_reset();
        m_owner  = 0;
        m_tenure = 0;
        m_last   = 2;
        sb_q.delete();
    endtask

    task automatic set_a(input logic r, input logic w, input int a1, input int a2,
                         input int aw, input logic [DW-1:0] d);
        bus.req_a = r; bus.we_a = w;
        bus.addr_rd1_a = AW'(a1); bus.addr_rd2_a = AW'(a2); bus.addr_wr_a = AW'(aw);
        bus.wdata_a = d;
    endtask

    task automatic set_b(input logic r, input logic w, input int a1, input int a2,
                         input int aw, input logic [DW-1:0] d);
        bus.req_b = r; bus.we_b = w;
        bus.addr_rd1_b = AW'(a1); bus.addr_rd2_b = AW'(a2); bus.addr_wr_b = AW'(aw);
        bus.wdata_b = d;
    endtask

    task automatic rand_a(input logic r);
        set_a(r, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), {$urandom, $urandom});
    endtask

    task automatic rand_b(input logic r);
        set_b(r, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), {$urandom, $urandom});
    endtask

    // One clock cycle: called just after a rising edge with inputs driven.
    task automatic cycle();
        logic          mine, other, we;
        logic [AW-1:0] a1, a2, aw;
        logic [DW-1:0] wd;
        exp_t          e;
        #1;
        mine = 1'b0; other = 1'b0; we = 1'b0;
        a1 = '0; a2 = '0; aw = '0; wd = '0;
        if (m_owner == 1) begin
            mine = bus.req_a; other = bus.req_b; we = bus.we_a;
            a1 = bus.addr_rd1_a; a2 = bus.addr_rd2_a; aw = bus.addr_wr_a; wd = bus.wdata_a;
        end else if (m_owner == 2) begin
            mine = bus.req_b; other = bus.req_a; we = bus.we_b;
            a1 = bus.addr_rd1_b; a2 = bus.addr_rd2_b; aw = bus.addr_wr_b; wd = bus.wdata_b;
        end
        chk("ram_port", 256'(ram_vec()), 256'({mine & we, a1, a2, aw, wd}));
        if (m_owner != 0 && mine) begin
            e.due = cyc + 1;
            e.who = (m_owner == 1) ? 2'b10 : 2'b01;
            e.d1  = m_mem[a1];
            e.d2  = m_mem[a2];
            sb_q.push_back(e);
            if (we) m_mem[aw] = wd;
        end
        if (m_owner == 0) begin
            m_tenure = 0;
            if (bus.req_a && bus.req_b) m_owner = (m_last == 1) ? 2 : 1;
            else if (bus.req_a) m_owner = 1;
            else if (bus.req_b) m_owner = 2;
        end else if (!mine) begin
            m_last   = m_owner;
            m_owner  = other ? 3 - m_owner : 0;
            m_tenure = 0;
        end else begin
            m_tenure++;
            if (other && m_tenure >= MB) begin
                m_last   = m_owner;
                m_owner  = 3 - m_owner;
                m_tenure = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("grant", 256'({bus.gnt_a, bus.gnt_b}), 256'({m_owner == 1, m_owner == 2}));
    endtask

    // Monitor: every read-data return must match the scoreboard head on time.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                chk("rvalid", 256'({bus.rvalid_a, bus.rvalid_b}), 256'(e.who));
                chk("rdata", 256'({bus.rdata1, bus.rdata2}), 256'({e.d1, e.d2}));
            end else begin
                chk("rvalid_idle", 256'({bus.rvalid_a, bus.rvalid_b}), 256'(2'b00));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ra, rb;
        for (int i = 0; i < int'(MemDepth); i++) begin
            env_mem[i] = '0;
            m_mem[i]   = '0;
        end
        rst = 1'b1;
        model_reset();
        set_a(1'b1, 1'b1, 3, 4, 5, 64'h1111);
        set_b(1'b1, 1'b1, 6, 7, 8, 64'h2222);

        // Reset with both requests held: everything stays quiet.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", 256'({bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b}), 256'(0));
        chk("reset_rdata", 256'({bus.rdata1, bus.rdata2}), 256'(0));
        chk("reset_ram", 256'(ram_vec()), 256'(0));
        #3 rst = 1'b0;
        set_a(1'b1, 1'b0, 0, 0, 0, 64'h0);
        set_b(1'b1, 1'b0, 0, 0, 0, 64'h0);
        cycle();  // A must win the first tie
        set_a(1'b0, 1'b0, 0, 0, 0, 64'h0);
        set_b(1'b0, 1'b0, 0, 0, 0, 64'h0);
        repeat (3) cycle();

        // A alone: write addr 5, then read it back.
        set_a(1'b1, 1'b1, 0, 1, 5, 64'hDEADBEEF_00000001);
        cycle();
        cycle();
        set_a(1'b1, 1'b0, 5, 2, 0, 64'h0);
        cycle();
        // Same-beat write and read of addr 7: old then new value.
        set_a(1'b1, 1'b1, 0, 0, 7, 64'h1);
        cycle();
        set_a(1'b1, 1'b1, 7, 5, 7, 64'h2);
        cycle();
        set_a(1'b1, 1'b0, 7, 7, 0, 64'h0);
        cycle();
        set_a(1'b0, 1'b0, 0, 0, 0, 64'h0);
        repeat (2) cycle();

        // Continuous contention: alternating 8-beat bursts.
        for (int i = 0; i < 48; i++) begin
            rand_a(1'b1);
            rand_b(1'b1);
            cycle();
            chk("no_dead_cycle", 256'(bus.gnt_a | bus.gnt_b), 256'(1));
        end
        rand_a(1'b0);
        rand_b(1'b0);
        repeat (2) cycle();

        // B alone for 20 cycles, then A joins.
        for (int i = 0; i < 20; i++) begin
            rand_a(1'b0);
            rand_b(1'b1);
            cycle();
        end
        for (int i = 0; i < 12; i++) begin
            rand_a(1'b1);
            rand_b(1'b1);
            cycle();
        end

        // Randomized traffic with sticky requests.
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 20) ra = ~ra;
            if ($urandom_range(0, 99) < 20) rb = ~rb;
            rand_a(ra);
            rand_b(rb);
            cycle();
        end

        // Reset in the middle of an A write burst.
        rand_b(1'b0);
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 1'b0, 1, 2, 3, 64'h0);
            cycle();
        end
        set_a(1'b1, 1'b1, 9, 9, 9, 64'hBAD0_0000_0000_BAD0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ram", 256'(ram_vec()), 256'(0));
        chk("midrst_gnt", 256'({bus.gnt_a, bus.gnt_b}), 256'(0));
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_nowrite", 256'(env_mem[9]), 256'(m_mem[9]));
        set_a(1'b1, 1'b0, 9, 0, 0, 64'h0);
        set_b(1'b1, 1'b0, 9, 0, 0, 64'h0);
        #2 rst = 1'b0;
        for (int i = 0; i < 20; i++) cycle();

        // Drain.
        set_a(1'b0, 1'b0, 0, 0, 0, 64'h0);
        set_b(1'b0, 1'b0, 0, 0, 0, 64'h0);
        repeat (3) cycle();
        chk("sb_drain", 256'(sb_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
